str_register_ctrl: RTL
======================

Name: str_register_ctrl

Overview:
- Sequencing and arbitration controller for the 128-bit string register (16 x 8-bit words).
- Shares the register between a pack requester and an unpack requester.
  - Pack: a byte stream is assembled into a right-aligned string.
  - Unpack: a string is serialised into a byte stream.
- Drives the register's str_load, word_load and shift controls, and forwards its outputs.

Parameters:
WORD_WIDTH, 8, width of one word/byte.
STR_WIDTH, 128, register width.
WORDS, STR_WIDTH/WORD_WIDTH (16), words per string.
CNT_W, 5, counter and length width (holds 0..WORDS).

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  pack byte valid
in_ready  output  1  pack byte accepted when in_valid and in_ready
in_data  input  WORD_WIDTH  pack byte
in_last  input  1  final byte of the packed string
str_valid  output  1  packed string available
str_ready  input  1  packed string consumer ready
str_data  output  STR_WIDTH  packed string (reg_str_out passthrough)
str_len  output  CNT_W  bytes in packed string, 1..16
ustr_valid  input  1  unpack string request
ustr_ready  output  1  unpack string accepted
ustr_data  input  STR_WIDTH  string to unpack (byte 0 at [7:0])
ustr_len  input  CNT_W  bytes to emit; 0 or >16 means 16
out_valid  output  1  unpacked byte valid
out_ready  input  1  unpacked byte consumer ready
out_data  output  WORD_WIDTH  reg_word_out passthrough
out_last  output  1  final unpacked byte
reg_str_load  output  1  to register str_load
reg_word_load  output  1  to register word_load
reg_rshift  output  1  to register rshift
reg_lshift  output  1  to register lshift; tied 0
reg_str_in  output  STR_WIDTH  = ustr_data
reg_word_in  output  WORD_WIDTH  = in_data
reg_str_out  input  STR_WIDTH  from register
reg_word_out  input  WORD_WIDTH  from register

Behaviour:
- Reset: state=IDLE, cnt=0, len=0, last_grant=unpack.
  - All handshake outputs and reg_* controls are 0.
  - str_len is 0.
- reg_* controls are combinational from state and handshake. They assert in the same cycle the handshake fires, so the register updates on that edge.
- The register applies load first, then shift, in one edge.
- FSM states: IDLE, PACK, PAD, PACK_DONE, UNPACK.
- IDLE: in_ready=0 and ustr_ready=0 except as below.
  - Requests are pack = in_valid and unpack = ustr_valid.
  - If both request, round-robin: grant the side not in last_grant.
  - Pack grant -> PACK, cnt=0. No byte is consumed in IDLE.
  - Unpack grant: ustr_ready=1 that cycle and reg_str_load=1.
    - len = clip(ustr_len), cnt=0.
    - Next state UNPACK.
- PACK: in_ready=1.
  - On each accepted byte, reg_word_load=1.
  - reg_rshift=1 unless the byte is final (cnt==15 or in_last).
  - cnt increments.
  - Final byte with cnt+1==16 -> PACK_DONE, len=16.
  - Final byte with n=cnt+1<16 -> PAD, len=n, padding counter=16-n.
- PAD: reg_rshift=1 each cycle for 16-n cycles, then PACK_DONE.
  - Result: byte 0 at [7:0], zero-filled above byte n-1.
  - Earlier register contents are fully displaced.
- PACK_DONE: str_valid=1 and str_len=len. No register controls are asserted, so data is stable.
  - When str_ready is high -> IDLE, last_grant=pack.
- UNPACK: out_valid=1, out_data=reg_word_out, out_last=(cnt==len-1).
  - On out_ready: reg_rshift=1 and cnt increments.
  - If out_last -> IDLE, last_grant=unpack.
- Held outputs: valid outputs stay high until the handshake; data does not change while valid.
- Mid-operation reset: return to the reset state immediately. The register is reset by the same rst.
- in_valid outside PACK is ignored, never dropped silently: the byte is held by the producer.

Optional Feature:
- Macro: STRCTRL_PERF_CNT_EN.
- When defined, three output ports are added:
  - pack_count [15:0]: increments on each str handshake, wraps at 0xFFFF.
  - unpack_count [15:0]: increments on each out_last handshake, wraps at 0xFFFF.
  - stall_cycles [15:0]: counts cycles with str_valid&!str_ready or out_valid&!out_ready, saturating at 0xFFFF.
  - All three reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Pack 16 bytes 0x00..0x0F, no backpressure.
  - str_valid after 17 cycles from grant.
  - str_data=0x0F0E..0100, str_len=16.
- Pack 3 bytes 0xAA,0xBB,0xCC with in_last on 0xCC.
  - 13 PAD cycles.
  - str_data=0x...00CCBBAA (upper 13 bytes zero), str_len=3.
- Unpack ustr_data=0x...0302_0100 with ustr_len=4, out_ready toggling 1/0.
  - Bytes 00,01,02,03 in order, out_last only on 03, then IDLE.
- in_valid and ustr_valid asserted together after reset.
  - Pack granted first, unpack next, then pack again (alternation).
- Hold str_ready=0 for 10 cycles in PACK_DONE.
  - str_data stable and no reg_* pulses.
  - With STRCTRL_PERF_CNT_EN defined, stall_cycles=10.
- Assert rst during UNPACK after 2 bytes.
  - All outputs 0, state IDLE.
  - A subsequent ustr_len=0 emits 16 bytes.

Source files
------------

// File: rtl/str_register_ctrl.sv
// Pack/unpack sequencer and arbiter for the shared 16-word string register.
// Optional perf counters are enabled with `define STRCTRL_PERF_CNT_EN.
module str_register_ctrl #(
    parameter int WORD_WIDTH = 8,
    parameter int STR_WIDTH  = 128,
    parameter int WORDS      = STR_WIDTH / WORD_WIDTH,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  str_valid,
    input  logic                  str_ready,
    output logic [STR_WIDTH-1:0]  str_data,
    output logic [CNT_W-1:0]      str_len,
    input  logic                  ustr_valid,
    output logic                  ustr_ready,
    input  logic [STR_WIDTH-1:0]  ustr_data,
    input  logic [CNT_W-1:0]      ustr_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  reg_str_load,
    output logic                  reg_word_load,
    output logic                  reg_rshift,
    output logic                  reg_lshift,
    output logic [STR_WIDTH-1:0]  reg_str_in,
    output logic [WORD_WIDTH-1:0] reg_word_in,
    input  logic [STR_WIDTH-1:0]  reg_str_out,
    input  logic [WORD_WIDTH-1:0] reg_word_out
`ifdef STRCTRL_PERF_CNT_EN
    ,
    output logic [15:0]           pack_count,
    output logic [15:0]           unpack_count,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        PAD,
        PACK_DONE,
        UNPACK
    } state_t;

    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LASTW = CNT_W'(WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic             last_pack;

    logic             grant_pack;
    logic             grant_unpack;
    logic             pack_final;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] ulen_clip;

    // Round-robin: pack wins a tie unless it had the previous grant
    assign grant_pack   = in_valid & (~ustr_valid | ~last_pack);
    assign grant_unpack = ustr_valid & ~grant_pack;
    assign pack_final   = (cnt == LASTW) | in_last;
    assign cnt_inc      = cnt + 1'b1;
    assign ulen_clip    = (ustr_len == '0 || ustr_len > FULL) ? FULL : ustr_len;

    assign str_data    = reg_str_out;
    assign out_data    = reg_word_out;
    assign reg_str_in  = ustr_data;
    assign reg_word_in = in_data;
    assign reg_lshift  = 1'b0;

    always_comb begin
        in_ready      = (state == PACK);
        str_valid     = (state == PACK_DONE);
        out_valid     = (state == UNPACK);
        ustr_ready    = (state == IDLE) & grant_unpack;
        str_len       = str_valid ? len : '0;
        out_last      = out_valid & (cnt == len - 1'b1);
        reg_str_load  = ustr_ready;
        reg_word_load = in_ready & in_valid;
        reg_rshift    = (in_ready & in_valid & ~pack_final)
                      | (state == PAD)
                      | (out_valid & out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            last_pack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_pack) begin
                        state <= PACK;
                        cnt   <= '0;
                    end else if (grant_unpack) begin
                        state <= UNPACK;
                        len   <= ulen_clip;
                        cnt   <= '0;
                    end
                end
                PACK: begin
                    if (in_valid) begin
                        cnt <= cnt_inc;
                        if (pack_final) begin
                            if (cnt_inc == FULL) begin
                                state <= PACK_DONE;
                                len   <= FULL;
                            end else begin
                                // cnt doubles as the pad countdown
                                state <= PAD;
                                len   <= cnt_inc;
                                cnt   <= FULL - cnt_inc;
                            end
                        end
                    end
                end
                PAD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) state <= PACK_DONE;
                end
                PACK_DONE: begin
                    if (str_ready) begin
                        state     <= IDLE;
                        last_pack <= 1'b1;
                    end
                end
                UNPACK: begin
                    if (out_ready) begin
                        cnt <= cnt_inc;
                        if (out_last) begin
                            state     <= IDLE;
                            last_pack <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STRCTRL_PERF_CNT_EN
    logic stall;
    assign stall = (str_valid & ~str_ready) | (out_valid & ~out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_count   <= '0;
            unpack_count <= '0;
            stall_cycles <= '0;
        end else begin
            if (str_valid & str_ready) pack_count <= pack_count + 1'b1;
            if (out_valid & out_ready & out_last)
                unpack_count <= unpack_count + 1'b1;
            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule
